// File: rtl/eeprom_pkg.sv
// Shared types and constants for the key-driven 24C64 page read/write master.
// Holds the FSM state encoding, byte-sequence segments and I2C bit-phase numbering.
package eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_TX_BYTE,
    ST_RX_ACK,
    ST_RSTART,
    ST_RX_BYTE,
    ST_TX_ACK,
    ST_STOP,
    ST_WAIT_WR
  } state_t;

  // Which byte of the transfer the master is currently transmitting.
  typedef enum logic [2:0] {
    SEG_CTRL_W,
    SEG_ADDR_H,
    SEG_ADDR_L,
    SEG_DATA,
    SEG_CTRL_R
  } seg_t;

  localparam logic [7:0] DEV_ADDR_W = 8'hA0;
  localparam logic [7:0] DEV_ADDR_R = 8'hA1;
  localparam logic [7:0] BASE_STEP  = 8'h10;

  localparam logic [2:0] BIT_MSB = 3'd7;
  localparam logic [2:0] BIT_LSB = 3'd0;

  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_SAMPLE = 2'd1;
  localparam logic [1:0] PH_HOLD   = 2'd2;
  localparam logic [1:0] PH_FALL   = 2'd3;

  function automatic logic scl_high_phase(input logic [1:0] ph);
    return (ph == PH_SAMPLE) || (ph == PH_HOLD);
  endfunction

endpackage

// File: rtl/eeprom_page_rd_wr_key_debounce.sv
// Two-flop synchroniser plus hold-time counter for one active-low push button.
// Emits a single-cycle press pulse once the key has stayed low long enough.
module key_debounce #(
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CNT - 2);

  logic meta_q, sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic press_q, press_d;

  // Counter saturates at its last value so a held key never re-fires.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d   = cnt_q + 1'b1;
      press_d = (cnt_q == CNT_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= key_n;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/eeprom_page_rd_wr.sv
// Key-driven I2C master: key1 page-writes 8 bytes, key2 page-reads 8 bytes into
// rd_buf_q, key3 bumps the write pattern base. SDA is open-drain, SCL push-pull.
module eeprom_page_rd_wr
  import eeprom_pkg::*;
#(
  parameter int          CLK_FREQ     = 50_000_000,
  parameter int          I2C_FREQ     = 100_000,
  parameter int          DEBOUNCE_CNT = 1_000_000,
  parameter int          TWR_CNT      = 250_000,
  parameter int          PAGE_BYTES   = 8,
  parameter logic [15:0] WORD_ADDR    = 16'h0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key1,
  input  logic key2,
  input  logic key3,
  inout  wire  i2c_sda,
  output logic i2c_scl
);

  localparam int PHASE_CLK = CLK_FREQ / I2C_FREQ / 4;
  localparam int CW = $clog2(PHASE_CLK + 1);
  localparam int BW = $clog2(PAGE_BYTES);
  localparam int WW = $clog2(TWR_CNT);
  localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CLK - 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(PAGE_BYTES - 1);
  localparam logic [WW-1:0] TWR_LAST   = WW'(TWR_CNT - 1);

  logic key1_pulse, key2_pulse, key3_pulse;

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key1 (
    .clk(clk), .rst_n(rst_n), .key_n(key1), .press(key1_pulse));
  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key2 (
    .clk(clk), .rst_n(rst_n), .key_n(key2), .press(key2_pulse));
  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key3 (
    .clk(clk), .rst_n(rst_n), .key_n(key3), .press(key3_pulse));

  state_t          state_q, state_d;
  seg_t            seg_q, seg_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      sh_q, sh_d;
  logic            op_rd_q, op_rd_d;
  logic            ack_err_q, ack_err_d;
  logic [7:0]      base_q, base_d;
  logic [WW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [7:0]      rd_buf_q [PAGE_BYTES];
  logic [7:0]      rd_buf_d [PAGE_BYTES];
  logic            scl_q, scl_d;
  logic            sda_oe_q, sda_oe_d;

  logic sda_in, tick, sample, bit_end, bus_active, mid_write;

  assign sda_in     = i2c_sda;
  assign tick       = (clk_cnt_q == PHASE_LAST);
  assign sample     = tick && (phase_q == PH_SAMPLE);
  assign bit_end    = tick && (phase_q == PH_FALL);
  assign bus_active = (state_q != ST_IDLE) && (state_q != ST_WAIT_WR);
  assign mid_write  = (state_q != ST_IDLE) && !op_rd_q;

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    clk_cnt_d  = '0;
    phase_d    = PH_SETUP;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_d       = tx_q;
    sh_d       = sh_q;
    op_rd_d    = op_rd_q;
    ack_err_d  = ack_err_q;
    base_d     = base_q;
    wr_cnt_d   = wr_cnt_q;
    rd_buf_d   = rd_buf_q;

    if (bus_active) begin
      clk_cnt_d = tick ? '0 : clk_cnt_q + 1'b1;
      phase_d   = tick ? phase_q + 2'd1 : phase_q;
    end

    if (key3_pulse && !key1_pulse && !key2_pulse && !mid_write)
      base_d = base_q + BASE_STEP;

    case (state_q)
      ST_IDLE: begin
        if (key1_pulse) begin
          state_d = ST_START;
          op_rd_d = 1'b0;
        end else if (key2_pulse) begin
          state_d = ST_START;
          op_rd_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_TX_BYTE;
          seg_d     = SEG_CTRL_W;
          tx_d      = DEV_ADDR_W;
          bit_cnt_d = BIT_MSB;
        end
      end
      ST_TX_BYTE: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LSB) state_d = ST_RX_ACK;
          else                      bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      // A NACK only sets the sticky flag; the sequence always runs to STOP.
      ST_RX_ACK: begin
        if (sample) ack_err_d = ack_err_q | sda_in;
        if (bit_end) begin
          bit_cnt_d = BIT_MSB;
          state_d   = ST_TX_BYTE;
          case (seg_q)
            SEG_CTRL_W: begin
              seg_d = SEG_ADDR_H;
              tx_d  = WORD_ADDR[15:8];
            end
            SEG_ADDR_H: begin
              seg_d = SEG_ADDR_L;
              tx_d  = WORD_ADDR[7:0];
            end
            SEG_ADDR_L: begin
              if (op_rd_q) begin
                state_d = ST_RSTART;
              end else begin
                seg_d      = SEG_DATA;
                byte_cnt_d = '0;
                tx_d       = base_q;
              end
            end
            SEG_DATA: begin
              if (byte_cnt_q == LAST_BYTE) begin
                state_d = ST_STOP;
              end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                tx_d       = base_q + 8'(byte_cnt_q) + 8'd1;
              end
            end
            SEG_CTRL_R: begin
              state_d    = ST_RX_BYTE;
              byte_cnt_d = '0;
            end
            default: state_d = ST_STOP;
          endcase
        end
      end
      ST_RSTART: begin
        if (bit_end) begin
          state_d   = ST_TX_BYTE;
          seg_d     = SEG_CTRL_R;
          tx_d      = DEV_ADDR_R;
          bit_cnt_d = BIT_MSB;
        end
      end
      ST_RX_BYTE: begin
        if (sample) sh_d = {sh_q[6:0], sda_in};
        if (bit_end) begin
          if (bit_cnt_q == BIT_LSB) begin
            rd_buf_d[byte_cnt_q] = sh_q;
            state_d              = ST_TX_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      ST_TX_ACK: begin
        if (bit_end) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_STOP;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            bit_cnt_d  = BIT_MSB;
            state_d    = ST_RX_BYTE;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          wr_cnt_d = '0;
          state_d  = op_rd_q ? ST_IDLE : ST_WAIT_WR;
        end
      end
      ST_WAIT_WR: begin
        if (wr_cnt_q == TWR_LAST) state_d  = ST_IDLE;
        else                      wr_cnt_d = wr_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line levels are decoded from state/phase here and registered so the pins never glitch.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_q)
      ST_START: begin
        scl_d    = (phase_q != PH_FALL);
        sda_oe_d = (phase_q == PH_HOLD) || (phase_q == PH_FALL);
      end
      ST_TX_BYTE: begin
        scl_d    = scl_high_phase(phase_q);
        sda_oe_d = !tx_q[bit_cnt_q];
      end
      ST_RX_ACK, ST_RX_BYTE: begin
        scl_d = scl_high_phase(phase_q);
      end
      ST_RSTART: begin
        scl_d    = scl_high_phase(phase_q);
        sda_oe_d = (phase_q == PH_HOLD) || (phase_q == PH_FALL);
      end
      ST_TX_ACK: begin
        scl_d    = scl_high_phase(phase_q);
        sda_oe_d = (byte_cnt_q != LAST_BYTE);
      end
      ST_STOP: begin
        scl_d    = (phase_q != PH_SETUP);
        sda_oe_d = (phase_q == PH_SETUP) || (phase_q == PH_SAMPLE);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      seg_q      <= SEG_CTRL_W;
      clk_cnt_q  <= '0;
      phase_q    <= PH_SETUP;
      bit_cnt_q  <= BIT_MSB;
      byte_cnt_q <= '0;
      tx_q       <= '0;
      sh_q       <= '0;
      op_rd_q    <= 1'b0;
      ack_err_q  <= 1'b0;
      base_q     <= '0;
      wr_cnt_q   <= '0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      for (int i = 0; i < PAGE_BYTES; i++) rd_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      clk_cnt_q  <= clk_cnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      op_rd_q    <= op_rd_d;
      ack_err_q  <= ack_err_d;
      base_q     <= base_d;
      wr_cnt_q   <= wr_cnt_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      rd_buf_q   <= rd_buf_d;
    end
  end

  assign i2c_scl = scl_q;
  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_eeprom_page_rd_wr.sv
// Directed bench for eeprom_page_rd_wr with shortened timing parameters,
// a pulled-up SDA line and a bus monitor / EEPROM slave model.
module tb_eeprom_page_rd_wr;
  import eeprom_pkg::*;

  localparam int TB_CLK_FREQ = 800_000;
  localparam int TB_I2C_FREQ = 100_000;
  localparam int TB_DEB      = 20;
  localparam int TB_TWR      = 40;
  localparam int TB_PAGE     = 8;
  localparam int EV_START    = 256;
  localparam int EV_STOP     = 257;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic key1 = 1'b1, key2 = 1'b1, key3 = 1'b1;
  wire  i2c_sda;
  logic i2c_scl;

  logic slave_low = 1'b0;
  logic nack_ctrl = 1'b0;
  assign i2c_sda = slave_low ? 1'b0 : 1'bz;
  pullup (i2c_sda);

  int total = 0;
  int bad = 0;
  int ev_q[$];
  int ack_q[$];

  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         mon_bits = 0, mon_idx = 0;
  logic [7:0] mon_sh = 8'h00;
  logic [7:0] rd_val;
  logic       slave_rd = 1'b0, slave_done = 1'b0;

  eeprom_page_rd_wr #(
    .CLK_FREQ(TB_CLK_FREQ), .I2C_FREQ(TB_I2C_FREQ), .DEBOUNCE_CNT(TB_DEB),
    .TWR_CNT(TB_TWR), .PAGE_BYTES(TB_PAGE), .WORD_ADDR(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key1(key1), .key2(key2), .key3(key3),
    .i2c_sda(i2c_sda), .i2c_scl(i2c_scl)
  );

  always #10 clk = ~clk;

  // Bus monitor and slave: logs START/STOP/bytes, ACKs master bytes, serves 0xA5+i on reads.
  always @(i2c_scl or i2c_sda) begin
    if (i2c_scl && prev_scl && prev_sda && !i2c_sda) begin
      ev_q.push_back(EV_START);
      mon_bits = 0; mon_idx = 0; slave_rd = 1'b0; slave_done = 1'b0;
    end else if (i2c_scl && prev_scl && !prev_sda && i2c_sda) begin
      ev_q.push_back(EV_STOP);
      mon_bits = 0; slave_low = 1'b0; slave_done = 1'b1;
    end else if (i2c_scl && !prev_scl) begin
      if (mon_bits < 8) begin
        mon_sh = {mon_sh[6:0], i2c_sda};
        mon_bits++;
        if (mon_bits == 8) begin
          ev_q.push_back(int'(mon_sh));
          if (mon_idx == 0) slave_rd = mon_sh[0];
        end
      end else begin
        ack_q.push_back(int'(i2c_sda));
        if (slave_rd && mon_idx >= 1 && i2c_sda) slave_done = 1'b1;
        mon_bits = 0;
        mon_idx++;
      end
    end else if (!i2c_scl && prev_scl) begin
      if (slave_rd && mon_idx >= 1) begin
        if (slave_done || mon_bits == 8) begin
          slave_low = 1'b0;
        end else begin
          rd_val    = 8'hA5 + 8'(mon_idx - 1);
          slave_low = !rd_val[7 - mon_bits];
        end
      end else begin
        slave_low = (mon_bits == 8) && !(nack_ctrl && mon_idx == 0);
      end
    end
    prev_scl = i2c_scl;
    prev_sda = i2c_sda;
  end

  task automatic press(input int which, input int n);
    @(negedge clk);
    if (which == 1) key1 = 1'b0;
    if (which == 2) key2 = 1'b0;
    if (which == 3) key3 = 1'b0;
    repeat (n) @(negedge clk);
    key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_to_idle(input int budget, output int wr_cycles, output bit timed_out);
    int n = 0;
    wr_cycles = 0;
    timed_out = 1'b1;
    while (n < budget && timed_out) begin
      @(negedge clk);
      if (dut.state_q == ST_WAIT_WR) wr_cycles++;
      if (dut.state_q == ST_IDLE) timed_out = 1'b0;
      n++;
    end
  endtask

  task automatic test_reset;
    int scl_lows = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (i2c_scl !== 1'b1) begin bad++; $display("[TB] FAIL reset_scl got=%b want=1", i2c_scl); end
    total++; if (i2c_sda !== 1'b1 || dut.sda_oe_q !== 1'b0) begin bad++; $display("[TB] FAIL reset_sda got=%b oe=%b want=1/0", i2c_sda, dut.sda_oe_q); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("[TB] FAIL reset_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
    total++; if (dut.base_q !== 8'h00 || dut.ack_err_q !== 1'b0) begin bad++; $display("[TB] FAIL reset_regs base=%h err=%b want=00/0", dut.base_q, dut.ack_err_q); end
    for (int i = 0; i < TB_PAGE; i++) begin
      total++; if (dut.rd_buf_q[i] !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdbuf[%0d] got=%h want=00", i, dut.rd_buf_q[i]); end
    end
    rst_n = 1'b1;
    ev_q.delete(); ack_q.delete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i2c_scl !== 1'b1 || i2c_sda !== 1'b1) scl_lows++;
    end
    total++; if (scl_lows != 0) begin bad++; $display("[TB] FAIL idle_bus got=%0d non-idle samples want=0", scl_lows); end
    total++; if (ev_q.size() != 0) begin bad++; $display("[TB] FAIL idle_events got=%0d want=0", ev_q.size()); end
  endtask

  task automatic test_short_press;
    ev_q.delete();
    press(1, 15);
    repeat (300) @(negedge clk);
    total++; if (ev_q.size() != 0) begin bad++; $display("[TB] FAIL short_press_events got=%0d want=0", ev_q.size()); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("[TB] FAIL short_press_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
    total++; if (dut.u_key1.cnt_q != 0) begin bad++; $display("[TB] FAIL short_press_cnt got=%0d want=0", dut.u_key1.cnt_q); end
  endtask

  task automatic test_write;
    int exp_ev[$];
    int wr;
    bit to;
    ev_q.delete(); ack_q.delete();
    exp_ev = {EV_START, 'hA0, 'h00, 'h00, 0, 1, 2, 3, 4, 5, 6, 7, EV_STOP};
    press(1, 30);
    run_to_idle(3000, wr, to);
    total++; if (to) begin bad++; $display("[TB] FAIL write_timeout got=busy want=idle"); end
    total++; if (ev_q.size() != exp_ev.size()) begin bad++; $display("[TB] FAIL write_len got=%0d want=%0d", ev_q.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++) begin
      total++; if (ev_q[i] != exp_ev[i]) begin bad++; $display("[TB] FAIL write_ev[%0d] got=%h want=%h", i, ev_q[i], exp_ev[i]); end
    end
    for (int i = 0; i < ack_q.size(); i++) begin
      total++; if (ack_q[i] != 0) begin bad++; $display("[TB] FAIL write_ack[%0d] got=%0d want=0", i, ack_q[i]); end
    end
    total++; if (wr != TB_TWR) begin bad++; $display("[TB] FAIL write_twr got=%0d want=%0d", wr, TB_TWR); end
    total++; if (dut.ack_err_q !== 1'b0) begin bad++; $display("[TB] FAIL write_ackerr got=%b want=0", dut.ack_err_q); end
    repeat (200) @(negedge clk);
    total++; if (ev_q.size() != exp_ev.size()) begin bad++; $display("[TB] FAIL write_single got=%0d want=%0d", ev_q.size(), exp_ev.size()); end
  endtask

  task automatic test_pattern;
    int wr;
    bit to;
    press(3, 30);
    total++; if (dut.base_q !== 8'h10) begin bad++; $display("[TB] FAIL pattern_step got=%h want=10", dut.base_q); end
    ev_q.delete();
    press(1, 30);
    run_to_idle(3000, wr, to);
    total++; if (to || ev_q.size() != 13) begin bad++; $display("[TB] FAIL pattern_len got=%0d to=%0d want=13", ev_q.size(), to); end
    for (int i = 0; i < 8 && (4 + i) < ev_q.size(); i++) begin
      total++; if (ev_q[4 + i] != ('h10 + i)) begin bad++; $display("[TB] FAIL pattern_data[%0d] got=%h want=%h", i, ev_q[4 + i], 'h10 + i); end
    end
    for (int i = 0; i < 14; i++) press(3, 30);
    total++; if (dut.base_q !== 8'hF0) begin bad++; $display("[TB] FAIL pattern_top got=%h want=f0", dut.base_q); end
    press(3, 30);
    total++; if (dut.base_q !== 8'h00) begin bad++; $display("[TB] FAIL pattern_wrap got=%h want=00", dut.base_q); end
  endtask

  task automatic test_read;
    int exp_ev[$];
    int wr;
    bit to;
    ev_q.delete(); ack_q.delete();
    exp_ev = {EV_START, 'hA0, 'h00, 'h00, EV_START, 'hA1,
              'hA5, 'hA6, 'hA7, 'hA8, 'hA9, 'hAA, 'hAB, 'hAC, EV_STOP};
    press(2, 30);
    run_to_idle(3000, wr, to);
    total++; if (to) begin bad++; $display("[TB] FAIL read_timeout got=busy want=idle"); end
    total++; if (wr != 0) begin bad++; $display("[TB] FAIL read_nowait got=%0d want=0", wr); end
    total++; if (ev_q.size() != exp_ev.size()) begin bad++; $display("[TB] FAIL read_len got=%0d want=%0d", ev_q.size(), exp_ev.size()); end
    for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++) begin
      total++; if (ev_q[i] != exp_ev[i]) begin bad++; $display("[TB] FAIL read_ev[%0d] got=%h want=%h", i, ev_q[i], exp_ev[i]); end
    end
    total++; if (ack_q.size() != 12) begin bad++; $display("[TB] FAIL read_acklen got=%0d want=12", ack_q.size()); end
    for (int i = 0; i < ack_q.size() && i < 12; i++) begin
      total++; if (ack_q[i] != ((i == 11) ? 1 : 0)) begin bad++; $display("[TB] FAIL read_ack[%0d] got=%0d want=%0d", i, ack_q[i], (i == 11) ? 1 : 0); end
    end
    for (int i = 0; i < TB_PAGE; i++) begin
      total++; if (dut.rd_buf_q[i] !== 8'(8'hA5 + i)) begin bad++; $display("[TB] FAIL read_buf[%0d] got=%h want=%h", i, dut.rd_buf_q[i], 8'(8'hA5 + i)); end
    end
  endtask

  task automatic test_nack;
    int wr;
    bit to;
    ev_q.delete(); ack_q.delete();
    nack_ctrl = 1'b1;
    press(1, 30);
    run_to_idle(3000, wr, to);
    nack_ctrl = 1'b0;
    total++; if (dut.ack_err_q !== 1'b1) begin bad++; $display("[TB] FAIL nack_flag got=%b want=1", dut.ack_err_q); end
    total++; if (to || ev_q.size() != 13) begin bad++; $display("[TB] FAIL nack_len got=%0d to=%0d want=13", ev_q.size(), to); end
    total++; if (ev_q.size() == 0 || ev_q[ev_q.size() - 1] != EV_STOP) begin bad++; $display("[TB] FAIL nack_stop got=missing want=stop"); end
    total++; if (ack_q.size() == 0 || ack_q[0] != 1) begin bad++; $display("[TB] FAIL nack_bit got=%0d want=1", (ack_q.size() == 0) ? -1 : ack_q[0]); end
  endtask

  task automatic test_busy_keys;
    int wr;
    bit to;
    int starts = 0;
    ev_q.delete();
    press(1, 30);
    repeat (100) @(negedge clk);
    press(2, 30);
    press(3, 30);
    run_to_idle(3000, wr, to);
    repeat (200) @(negedge clk);
    foreach (ev_q[i]) if (ev_q[i] == EV_START) starts++;
    total++; if (starts != 1) begin bad++; $display("[TB] FAIL busy_starts got=%0d want=1", starts); end
    total++; if (dut.base_q !== 8'h00) begin bad++; $display("[TB] FAIL busy_key3 got=%h want=00", dut.base_q); end
    total++; if (to || dut.state_q !== ST_IDLE) begin bad++; $display("[TB] FAIL busy_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_reset_mid;
    int starts = 0;
    ev_q.delete();
    press(1, 30);
    repeat (110) @(negedge clk);
    total++; if (dut.state_q !== ST_TX_BYTE) begin bad++; $display("[TB] FAIL midrst_busy got=%0d want=%0d", dut.state_q, ST_TX_BYTE); end
    rst_n = 1'b0;
    #1;
    total++; if (i2c_scl !== 1'b1) begin bad++; $display("[TB] FAIL midrst_scl got=%b want=1", i2c_scl); end
    total++; if (dut.sda_oe_q !== 1'b0 || i2c_sda !== 1'b1) begin bad++; $display("[TB] FAIL midrst_sda got=%b oe=%b want=1/0", i2c_sda, dut.sda_oe_q); end
    total++; if (dut.state_q !== ST_IDLE || dut.ack_err_q !== 1'b0) begin bad++; $display("[TB] FAIL midrst_state got=%0d err=%b want=%0d/0", dut.state_q, dut.ack_err_q, ST_IDLE); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    foreach (ev_q[i]) if (ev_q[i] == EV_START) starts++;
    total++; if (starts != 1 || i2c_scl !== 1'b1) begin bad++; $display("[TB] FAIL midrst_quiet got=%0d starts scl=%b want=1/1", starts, i2c_scl); end
  endtask

  initial begin
    $display("[TB] starting eeprom_page_rd_wr bench");
    test_reset();
    test_short_press();
    test_write();
    test_pattern();
    test_read();
    test_nack();
    test_busy_keys();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
